// File: rtl/rf_seq_pkg.sv
// Shared opcode and state encodings for the two-entry register-file sequencer.
// Imported by the ALU, the interface users and the top-level FSM.
package rf_seq_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_SWAP_A = 3'd2,
        ST_SWAP_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rf_seq_if.sv
// Command handshake plus register-file drive/read bus between the sequencer and its environment.
// The master side is the sequencer; the slave side is the command source and register file.
interface rf_seq_if #(parameter int N = 4);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic         cmd_dst;
    logic         cmd_src_a;
    logic         cmd_src_b;
    logic [N-1:0] cmd_imm;

    logic         rf_sa;
    logic         rf_sb;
    logic         rf_da;
    logic         rf_w;
    logic [N-1:0] rf_d;
    logic [N-1:0] rf_a;
    logic [N-1:0] rf_b;

    logic         done;
    logic [N-1:0] result;
    logic         carry;

    modport master (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  rf_a, rf_b,
        output cmd_ready, rf_sa, rf_sb, rf_da, rf_w, rf_d,
        output done, result, carry
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output rf_a, rf_b,
        input  cmd_ready, rf_sa, rf_sb, rf_da, rf_w, rf_d,
        input  done, result, carry
    );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational write-data generator: selects immediate, A bus, A+B sum or B bus by opcode.
// SWAP maps to the B bus so the first swap write can reuse this path.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] imm,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] data,
    output logic         carry
);

    logic [N:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        data  = '0;
        carry = 1'b0;
        case (op)
            OP_LOAD: data = imm;
            OP_COPY: data = a;
            OP_ADD: begin
                data  = sum[N-1:0];
                carry = sum[N];
            end
            default: data = b;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Command-driven write/read controller for the two-entry register file.
// state     | meaning
// ST_IDLE   | ready for a command
// ST_EXEC   | single write for LOAD/COPY/ADD
// ST_SWAP_A | R0 <= R1, capture old R0 in tmp
// ST_SWAP_B | R1 <= tmp
// ST_DONE   | done pulse, no write
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    rf_seq_if.master bus
);

    state_t       state_q;
    state_t       state_d;

    logic [1:0]   op_q;
    logic         dst_q;
    logic         src_a_q;
    logic         src_b_q;
    logic [N-1:0] imm_q;
    logic [N-1:0] tmp_q;
    logic [N-1:0] result_q;
    logic         carry_q;

    logic         accept;
    logic         write_raw;
    logic [N-1:0] alu_data;
    logic         alu_carry;

    rf_seq_alu #(.N(N)) u_alu (
        .op    (op_q),
        .imm   (imm_q),
        .a     (bus.rf_a),
        .b     (bus.rf_b),
        .data  (alu_data),
        .carry (alu_carry)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE) & ~rst;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign bus.rf_w      = write_raw & ~rst;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;

    always_comb begin
        state_d    = state_q;
        bus.rf_sa  = 1'b0;
        bus.rf_sb  = 1'b0;
        bus.rf_da  = 1'b0;
        bus.rf_d   = '0;
        write_raw  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = (bus.cmd_op == OP_SWAP) ? ST_SWAP_A : ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.rf_sa = src_a_q;
                bus.rf_sb = src_b_q;
                bus.rf_da = dst_q;
                bus.rf_d  = alu_data;
                write_raw = 1'b1;
                state_d   = ST_DONE;
            end
            ST_SWAP_A: begin
                // op_q is SWAP here, so the ALU forwards the B bus (old R1)
                bus.rf_sb = 1'b1;
                bus.rf_d  = alu_data;
                write_raw = 1'b1;
                state_d   = ST_SWAP_B;
            end
            ST_SWAP_B: begin
                bus.rf_da = 1'b1;
                bus.rf_d  = tmp_q;
                write_raw = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            dst_q    <= 1'b0;
            src_a_q  <= 1'b0;
            src_b_q  <= 1'b0;
            imm_q    <= '0;
            tmp_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= bus.cmd_op;
                dst_q   <= bus.cmd_dst;
                src_a_q <= bus.cmd_src_a;
                src_b_q <= bus.cmd_src_b;
                imm_q   <= bus.cmd_imm;
            end
            case (state_q)
                ST_EXEC: begin
                    result_q <= alu_data;
                    if (op_q == OP_ADD) begin
                        carry_q <= alu_carry;
                    end
                end
                ST_SWAP_A: tmp_q    <= bus.rf_a;
                ST_SWAP_B: result_q <= tmp_q;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Command-driven controller that sits on the write/read side of the two-entry register file. It accepts one register-transfer command per handshake and drives the register file's select, address, write-enable and data ports. It computes the write data from the register file's combinational A/B read buses. It is the initiator that the register file responds to in the lab datapath.

## Interface
Parameters:
- N, 4, data width; must match the register file width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 LOAD, 01 COPY, 10 ADD, 11 SWAP.
- cmd_dst  in  1  destination register address.
- cmd_src_a  in  1  source A address; COPY and ADD only.
- cmd_src_b  in  1  source B address; ADD only.
- cmd_imm  in  N  immediate; LOAD only.
- rf_sa  out  1  drives register file select A.
- rf_sb  out  1  drives register file select B.
- rf_da  out  1  drives register file write address.
- rf_w  out  1  drives register file write enable.
- rf_d  out  N  drives register file write data.
- rf_a  in  N  register file A bus; combinational read.
- rf_b  in  N  register file B bus; combinational read.
- done  out  1  one-cycle pulse when a command completes.
- result  out  N  last value written by a completed command.
- carry  out  1  carry-out of the last ADD.

## Operation
- States: IDLE, EXEC, SWAP_A, SWAP_B, DONE.
- Command acceptance:
  - cmd_ready = (state==IDLE) & ~rst.
  - Accept on cmd_valid & cmd_ready at a clock edge.
  - Latch op, dst, src_a, src_b and imm into internal registers.
- Transitions out of IDLE: LOAD, COPY and ADD go to EXEC; SWAP goes to SWAP_A.
- EXEC (one cycle): rf_sa=src_a, rf_sb=src_b, rf_da=dst, rf_w=1. Write data by op:
  - LOAD: rf_d = imm.
  - COPY: rf_d = rf_a.
  - ADD: rf_d = (rf_a + rf_b) mod 2^N; carry <= bit N of the (N+1)-bit sum.
  - result <= rf_d. Next state DONE.
- SWAP_A: rf_sa=0, rf_sb=1, rf_da=0, rf_d=rf_b, rf_w=1; tmp <= rf_a. Next state SWAP_B.
- SWAP_B: rf_da=1, rf_d=tmp, rf_w=1; result <= tmp. Next state DONE.
- SWAP ignores dst, src_a and src_b.
- DONE: done=1, rf_w=0. Next state IDLE.
- carry is changed only by ADD. LOAD, COPY and SWAP hold it.
- Outputs in IDLE and DONE: rf_sa, rf_sb, rf_da and rf_d are 0; rf_w is 0.
- Write gating: rf_w is gated combinationally by ~rst, so no register-file write occurs in any cycle where rst is high.
- Reset (sync):
  - state becomes IDLE; tmp, result and carry become 0; done becomes 0.
  - All rf_* outputs are 0.
  - A command in flight is abandoned. Any write already committed stays; the pending SWAP_B write is lost.
- cmd_valid outside IDLE is ignored. The command is not consumed until a later IDLE cycle.
- ADD or COPY with a source equal to dst reads the old value; the write lands at the end of the cycle.

## Timing
- Commands accepted at edge k.
- LOAD, COPY, ADD:
  - EXEC in cycle k+1; the register file updates at edge k+2.
  - done, result and carry are valid in cycle k+2.
  - cmd_ready is high again in cycle k+3.
- SWAP:
  - Writes in cycles k+1 and k+2.
  - done in cycle k+3; ready in k+4.
- Maximum throughput: one command per 3 cycles (4 for SWAP).
- rf_* outputs are decoded from state and latched fields only. rf_d additionally depends combinationally on rf_a and rf_b, which is one combinational path through the register file read muxes.

## Structure
- Package rf_seq_pkg holds:
  - opcode constants OP_LOAD, OP_COPY, OP_ADD, OP_SWAP;
  - state encoding constants.
- Sub-module rf_seq_alu is combinational. It takes op, imm, rf_a and rf_b, and returns the N-bit write data and the carry bit.
- The FSM, command latch, tmp, result and carry registers live in rf_sequencer.
- The bench instantiates the existing register file beside rf_sequencer and ties rst to both.

## Test plan
- Reset, then LOAD imm=4'hA dst=0 -> cycle k+1: rf_w=1, rf_da=0, rf_d=A. Cycle k+2: done=1, result=A. R0=A.
- LOAD R1=5, then ADD a=0 b=1 dst=1 -> R1=F, carry=0. Then ADD a=0 b=1 dst=0 -> R0=9 (A+F), carry=1.
- COPY src_a=1 dst=0 with R1=F -> R0=F, carry unchanged, done at k+2.
- SWAP with R0=3, R1=C -> rf_w high in k+1 and k+2, done at k+3. Result: R0=C, R1=3, result=3.
- cmd_valid held high continuously with LOAD commands -> accepts at k, k+3, k+6. cmd_ready is low in EXEC and DONE.
- rst high during EXEC of LOAD imm=7 dst=1 -> rf_w=0 that cycle, R1 unchanged. Next cycle: state IDLE, done=0, carry=0, result=0. rst high during SWAP_B -> R0 already swapped, R1 unchanged.
